csr_rmw_unit: RTL

Read-modify-write sequencer for Zicsr instructions, sitting between the execute stage and the CSR register file. It accepts one CSR instruction per handshake and reads the old value through the CSR file's combinational read port. It computes the new value (write, set or clear), issues at most one single-cycle write on the CSR file's write port, and returns the old value to the writeback path under a valid/ready handshake.

---
 rtl/csr_rmw_unit_pkg.sv | 38 +++
 rtl/csr_rmw_unit_alu.sv | 64 ++++++
 rtl/csr_rmw_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/csr_rmw_unit_pkg.sv
// csr_rmw_unit_pkg: shared definitions for the CSR read-modify-write unit.
//   - default data / address widths
//   - Zicsr funct3 operation encodings
//   - sequencer state encoding
package csr_rmw_unit_pkg;

  localparam int unsigned CSR_XLEN   = 64;
  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned CSR_OP_W   = 3;
  localparam int unsigned ZIMM_W     = 5;
  localparam int unsigned REG_IDX_W  = 5;

  // funct3 encodings; bit 2 selects the immediate form
  localparam logic [CSR_OP_W-1:0] CSR_OP_RW  = 3'b001;
  localparam logic [CSR_OP_W-1:0] CSR_OP_RS  = 3'b010;
  localparam logic [CSR_OP_W-1:0] CSR_OP_RC  = 3'b011;
  localparam logic [CSR_OP_W-1:0] CSR_OP_RWI = 3'b101;
  localparam logic [CSR_OP_W-1:0] CSR_OP_RSI = 3'b110;
  localparam logic [CSR_OP_W-1:0] CSR_OP_RCI = 3'b111;

  // Low two funct3 bits pick the function regardless of operand form
  localparam logic [1:0] CSR_FN_RW = CSR_OP_RW[1:0];
  localparam logic [1:0] CSR_FN_RS = CSR_OP_RS[1:0];
  localparam logic [1:0] CSR_FN_RC = CSR_OP_RC[1:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } csr_state_e;

  // Immediate forms take the zero-extended zimm field as operand
  function automatic logic op_is_imm(input logic [CSR_OP_W-1:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/csr_rmw_unit_alu.sv
// csr_alu: combinational new-value and write-enable computation for one
// Zicsr instruction. The returned write enable does not include the
// read-only-space check; the sequencer applies that.
// Ports:
//   op_i        funct3 of the instruction
//   old_i       current CSR value
//   src_i       rs1 value (register forms)
//   zimm_i      5-bit immediate (immediate forms)
//   rs1_zero_i  rs1 index is x0
//   new_val_c_o value to write
//   we_c_o      write required
module csr_alu
  import csr_rmw_unit_pkg::*;
#(
  parameter int unsigned XLEN = CSR_XLEN
) (
  input  logic [CSR_OP_W-1:0] op_i,
  input  logic [XLEN-1:0]     old_i,
  input  logic [XLEN-1:0]     src_i,
  input  logic [ZIMM_W-1:0]   zimm_i,
  input  logic                rs1_zero_i,
  output logic [XLEN-1:0]     new_val_c_o,
  output logic                we_c_o
);

  logic [XLEN-1:0] operand;
  logic            operand_zero;

  // Operand select and the "no source bits" condition used for suppression
  always_comb begin
    operand      = src_i;
    operand_zero = rs1_zero_i;
    if (op_is_imm(op_i)) begin
      operand      = XLEN'(zimm_i);
      operand_zero = (zimm_i == ZIMM_W'(0));
    end
  end

  // RW always writes; RS/RC skip the write when no bits would be touched;
  // reserved function 00 never writes
  always_comb begin
    new_val_c_o = old_i;
    we_c_o      = 1'b0;
    case (op_i[1:0])
      CSR_FN_RW: begin
        new_val_c_o = operand;
        we_c_o      = 1'b1;
      end
      CSR_FN_RS: begin
        new_val_c_o = old_i | operand;
        we_c_o      = ~operand_zero;
      end
      CSR_FN_RC: begin
        new_val_c_o = old_i & ~operand;
        we_c_o      = ~operand_zero;
      end
      default: begin
        new_val_c_o = old_i;
        we_c_o      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_rmw_unit.sv
// csr_rmw_unit: read-modify-write sequencer between execute and the CSR file.
// IDLE accepts a request, READ samples the CSR file's combinational read
// port, WRITE issues at most one single-cycle write, RESP returns the old
// value under a valid/ready handshake. Minimum four cycles per instruction.
// Optional feature macro: CSR_RMW_ILLEGAL_EN -- flags and suppresses writes
// into the read-only address space (addr[11:10] == 2'b11).
// Ports:
//   clk, rst                       clock, async active-low reset
//   req_*_i / req_ready_o          request handshake and payload
//   csr_raddr_o / csr_rdata_i      CSR file read port
//   csr_we_o/csr_waddr_o/csr_wdata_o  CSR file write port
//   resp_*_o / resp_ready_i        response handshake and payload
module csr_rmw_unit
  import csr_rmw_unit_pkg::*;
#(
  parameter int unsigned XLEN   = CSR_XLEN,
  parameter int unsigned CSR_AW = CSR_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [CSR_OP_W-1:0]  req_op_i,
  input  logic [CSR_AW-1:0]    req_addr_i,
  input  logic [XLEN-1:0]      req_src_i,
  input  logic [ZIMM_W-1:0]    req_zimm_i,
  input  logic                 req_rs1_zero_i,
  input  logic [REG_IDX_W-1:0] req_rd_i,
  output logic [CSR_AW-1:0]    csr_raddr_o,
  input  logic [XLEN-1:0]      csr_rdata_i,
  output logic                 csr_we_o,
  output logic [CSR_AW-1:0]    csr_waddr_o,
  output logic [XLEN-1:0]      csr_wdata_o,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [REG_IDX_W-1:0] resp_rd_o,
  output logic [XLEN-1:0]      resp_data_o,
  output logic                 resp_illegal_o
);

  csr_state_e state_q, state_d;

  logic [CSR_OP_W-1:0]  op_q;
  logic [CSR_AW-1:0]    addr_q;
  logic [XLEN-1:0]      src_q;
  logic [ZIMM_W-1:0]    zimm_q;
  logic                 rs1_zero_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic [XLEN-1:0]      old_q;
  logic [XLEN-1:0]      new_q;
  logic                 we_q;

  logic [XLEN-1:0]      alu_new_c;
  logic                 alu_we_c;
  logic                 ro_write_c;

  csr_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op_i        (op_q),
    .old_i       (csr_rdata_i),
    .src_i       (src_q),
    .zimm_i      (zimm_q),
    .rs1_zero_i  (rs1_zero_q),
    .new_val_c_o (alu_new_c),
    .we_c_o      (alu_we_c)
  );

`ifdef CSR_RMW_ILLEGAL_EN
  logic illegal_q;

  // A real write aimed at the read-only space becomes an illegal access
  assign ro_write_c = alu_we_c && (addr_q[CSR_AW-1 -: 2] == 2'b11);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_q <= 1'b0;
    end else if (state_q == ST_READ) begin
      illegal_q <= ro_write_c;
    end
  end
`else
  // Hardwired CSRs ignore writes, so the write goes out unchanged
  assign ro_write_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid_i) state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (resp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch in IDLE; old/new value and write decision captured in READ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      zimm_q     <= '0;
      rs1_zero_q <= 1'b0;
      rd_q       <= '0;
      old_q      <= '0;
      new_q      <= '0;
      we_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_q       <= req_op_i;
            addr_q     <= req_addr_i;
            src_q      <= req_src_i;
            zimm_q     <= req_zimm_i;
            rs1_zero_q <= req_rs1_zero_i;
            rd_q       <= req_rd_i;
          end
        end
        ST_READ: begin
          old_q <= csr_rdata_i;
          new_q <= alu_new_c;
          we_q  <= alu_we_c & ~ro_write_c;
        end
        default: ;
      endcase
    end
  end

  // Output decode from the state and captured registers
  always_comb begin
    req_ready_o    = 1'b0;
    csr_raddr_o    = addr_q;
    csr_waddr_o    = addr_q;
    csr_we_o       = 1'b0;
    csr_wdata_o    = '0;
    resp_valid_o   = 1'b0;
    resp_rd_o      = '0;
    resp_data_o    = '0;
    resp_illegal_o = 1'b0;
    case (state_q)
      ST_IDLE: req_ready_o = 1'b1;
      ST_WRITE: begin
        if (we_q) begin
          csr_we_o    = 1'b1;
          csr_wdata_o = new_q;
        end
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_rd_o    = rd_q;
        resp_data_o  = old_q;
`ifdef CSR_RMW_ILLEGAL_EN
        resp_illegal_o = illegal_q;
`endif
      end
      default: ;
    endcase
  end

endmodule
